// File: rtl/serial_adder_pkg.sv
// Shared constants and state encoding for the serial nibble adder.
package serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } sna_state_t;

endpackage

// File: rtl/serial_nibble_adder_rca4_cin.sv
// Combinational 4-bit ripple-carry adder with carry-in, built from four full-adder stages.
module rca4_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic c1_s;
  logic c2_s;
  logic c3_s;

  assign s[0] = a[0] ^ b[0] ^ cin;
  assign c1_s = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));

  assign s[1] = a[1] ^ b[1] ^ c1_s;
  assign c2_s = (a[1] & b[1]) | (c1_s & (a[1] ^ b[1]));

  assign s[2] = a[2] ^ b[2] ^ c2_s;
  assign c3_s = (a[2] & b[2]) | (c2_s & (a[2] ^ b[2]));

  assign s[3] = a[3] ^ b[3] ^ c3_s;
  assign cout = (a[3] & b[3]) | (c3_s & (a[3] ^ b[3]));

endmodule

// File: rtl/serial_nibble_adder.sv
// Wide adder that streams one nibble per clock through a single 4-bit ripple slice,
// with valid/ready handshakes on both operand and result sides.
module serial_nibble_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
      $error("serial_nibble_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  sna_state_t       state_r;
  sna_state_t       state_nx_s;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [3:0]       s_nib_s;
  logic             c_nib_s;
  logic             last_s;

  // Operand registers shift right each ADD cycle, so the active nibble is always the low one.
  rca4_cin u_rca (
    .a    (a_r[NIBBLE_W-1:0]),
    .b    (b_r[NIBBLE_W-1:0]),
    .cin  (carry_r),
    .s    (s_nib_s),
    .cout (c_nib_s)
  );

  assign last_s = (idx_r == LAST_IDX);

  // Next-state decode for the IDLE/ADD/DONE sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nx_s = ADD;
        else          state_nx_s = IDLE;
      end
      ADD: begin
        if (last_s) state_nx_s = DONE;
        else        state_nx_s = ADD;
      end
      DONE: begin
        if (out_ready) state_nx_s = IDLE;
        else           state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, datapath registers and registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      carry_r     <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == DONE);
      busy_r      <= (state_nx_s != IDLE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= in_a;
            b_r     <= in_b;
            carry_r <= in_cin;
            idx_r   <= {IDX_W{1'b0}};
          end
        end
        ADD: begin
          a_r     <= a_r >> NIBBLE_W;
          b_r     <= b_r >> NIBBLE_W;
          carry_r <= c_nib_s;
          idx_r   <= idx_r + IDX_W'(1);
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_r == IDX_W'(i)) sum_r[i*NIBBLE_W +: NIBBLE_W] <= s_nib_s;
          end
          if (last_s) cout_r <= c_nib_s;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_sum   = sum_r;
  assign out_cout  = cout_r;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed self-checking bench: a 16-bit instance for protocol cases, a 4-bit instance swept exhaustively.
module tb_serial_nibble_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid16, in_ready16, in_cin16, out_valid16, out_ready16, out_cout16, busy16;
  logic [15:0] in_a16, in_b16, out_sum16;

  logic        in_valid4, in_ready4, in_cin4, out_valid4, out_ready4, out_cout4, busy4;
  logic [3:0]  in_a4, in_b4, out_sum4;

  int checks = 0;
  int errors = 0;
  int pulses4 = 0;

  always #5 clk = ~clk;

  serial_nibble_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(in_a16), .in_b(in_b16), .in_cin(in_cin16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_sum(out_sum16), .out_cout(out_cout16), .busy(busy16)
  );

  serial_nibble_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(out_sum4), .out_cout(out_cout4), .busy(busy4)
  );

  always @(posedge clk) begin
    if (out_valid4 === 1'b1) pulses4 <= pulses4 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    in_a16 = a; in_b16 = b; in_cin16 = cin; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
  endtask

  task automatic wait_valid16(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((out_valid16 !== 1'b1) && (n < 20));
  endtask

  initial begin
    int  n;
    logic seen;
    logic [4:0] exp5;

    rst = 1'b0;
    in_valid16 = 1'b0; in_a16 = 16'h0; in_b16 = 16'h0; in_cin16 = 1'b0; out_ready16 = 1'b1;
    in_valid4  = 1'b0; in_a4  = 4'h0;  in_b4  = 4'h0;  in_cin4  = 1'b0; out_ready4  = 1'b1;

    // 1: asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid16, 0);
    check("rst_out_sum",   out_sum16,   16'h0000);
    check("rst_out_cout",  out_cout16,  0);
    check("rst_busy",      busy16,      0);
    check("rst_in_ready",  in_ready16,  1);
    tick();
    rst = 1'b0;
    tick();

    // 2: carry ripples through every nibble, latency of 4 edges
    accept16(16'hFFFF, 16'h0001, 1'b0);
    check("t2_busy_after_accept", busy16, 1);
    wait_valid16(n);
    check("t2_latency", n, 4);
    check("t2_sum",  out_sum16,  16'h0000);
    check("t2_cout", out_cout16, 1);
    tick();
    check("t2_valid_drop", out_valid16, 0);
    check("t2_ready_back", in_ready16, 1);

    // 3: carry-in path
    accept16(16'h1234, 16'h4321, 1'b1);
    wait_valid16(n);
    check("t3_latency", n, 4);
    check("t3_sum",  out_sum16,  16'h5556);
    check("t3_cout", out_cout16, 0);
    tick();

    // 4: backpressure while a new operation waits
    out_ready16 = 1'b0;
    accept16(16'h8000, 16'h8000, 1'b0);
    wait_valid16(n);
    check("t4_latency", n, 4);
    in_a16 = 16'h0102; in_b16 = 16'h0304; in_cin16 = 1'b0; in_valid16 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_hold_valid", out_valid16, 1);
      check("t4_hold_sum",   out_sum16,   16'h0000);
      check("t4_hold_cout",  out_cout16,  1);
      check("t4_hold_ready", in_ready16,  0);
    end
    out_ready16 = 1'b1;
    tick();
    check("t4_release_valid", out_valid16, 0);
    check("t4_release_ready", in_ready16, 1);
    tick();
    check("t4_pending_accepted", busy16, 1);
    in_valid16 = 1'b0;
    wait_valid16(n);
    check("t4_latency2", n, 4);
    check("t4_sum2",  out_sum16,  16'h0406);
    check("t4_cout2", out_cout16, 0);
    tick();
    check("t4_valid_drop", out_valid16, 0);

    // 5: reset while the nibble index is 2
    accept16(16'hABCD, 16'h1111, 1'b1);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", out_valid16, 0);
    check("t5_rst_busy",  busy16,      0);
    check("t5_rst_ready", in_ready16,  1);
    check("t5_rst_sum",   out_sum16,   16'h0000);
    check("t5_rst_cout",  out_cout16,  0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid16 !== 1'b0) seen = 1'b1;
    end
    check("t5_no_pulse", seen, 0);
    accept16(16'h00FF, 16'h0001, 1'b0);
    wait_valid16(n);
    check("t5_latency", n, 4);
    check("t5_sum",  out_sum16,  16'h0100);
    check("t5_cout", out_cout16, 0);
    tick();

    // 6: WIDTH=4 exhaustive, back-to-back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          in_a4 = 4'(a); in_b4 = 4'(b); in_cin4 = 1'(c); in_valid4 = 1'b1;
          tick();
          in_valid4 = 1'b0;
          tick();
          exp5 = 5'(a) + 5'(b) + 5'(c);
          check("w4_result", {out_valid4, out_cout4, out_sum4}, {1'b1, exp5});
          tick();
        end
      end
    end
    check("w4_pulse_count", pulses4, 512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_nibble_adder.md
Name: serial_nibble_adder

Overview:
Multi-precision adder that consumes WIDTH-bit operands through a valid/ready handshake. It adds one 4-bit nibble per clock through a 4-bit ripple-carry slice, holding the inter-nibble carry in a flop. This chains the team's 4-bit ripple-carry datapath into wide additions without widening the combinational carry chain. It returns {cout, sum} on an output valid/ready handshake.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4 (elaboration-time check).
NIBBLES, WIDTH/4, derived localparam; number of ADD cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand transfer request
in_ready  output  1  high only in IDLE
in_a  input  WIDTH  operand A, sampled on accept
in_b  input  WIDTH  operand B, sampled on accept
in_cin  input  1  carry-in, sampled on accept
out_valid  output  1  result available; high only in DONE
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  registered sum
out_cout  output  1  registered final carry
busy  output  1  high in ADD or DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; nibble index=0; carry flop=0; operand regs=0.
  - out_sum=0, out_cout=0, out_valid=0, busy=0, in_ready=1.
- State IDLE:
  - in_ready=1.
  - Accept when in_valid&&in_ready on a rising edge: latch in_a, in_b; carry<=in_cin; idx<=0; go to ADD.
- State ADD: one nibble per cycle.
  - {c,s} = a[idx*4+:4] + b[idx*4+:4] + carry.
  - out_sum[idx*4+:4]<=s; carry<=c; idx<=idx+1.
  - On the edge processing idx==NIBBLES-1: out_cout<=c and go to DONE.
  - Inputs are ignored throughout ADD.
- State DONE:
  - out_valid=1; out_sum and out_cout held stable.
  - When out_ready: go to IDLE; out_valid drops the next cycle.
  - in_ready=0, so in_valid is ignored. A new operation can be accepted no earlier than the cycle after the output transfer.
- Latency: out_valid rises exactly NIBBLES rising edges after the accepting edge.
  - Minimum initiation interval is NIBBLES+2 cycles (including one IDLE cycle).
- Arithmetic:
  - Result equals the (WIDTH+1)-bit value in_a+in_b+in_cin, with out_cout as the MSB.
  - Wrap-around: out_sum is modulo 2^WIDTH; overflow is reported only via out_cout.
- out_sum/out_cout are meaningful only while out_valid=1. While in ADD they hold partially updated values; benches must not check them then.
- out_ready is held high indefinitely: each result is presented for exactly one cycle.
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-operation (ADD or DONE):
  - The partial or held result is discarded and all registers return to reset values.
  - No out_valid pulse occurs for the aborted operation.
- WIDTH=4 degenerate case: a single ADD cycle; same protocol.

Decomposition:
- Package serial_adder_pkg:
  - NIBBLE_W=4 constant.
  - typedef enum logic [1:0] {IDLE, ADD, DONE} sna_state_t.
- Sub-module rca4_cin: purely combinational 4-bit ripple-carry adder with carry-in.
  - Ports: a[3:0], b[3:0], cin -> s[3:0], cout.
  - Built from four full-adder stages. It is the only arithmetic in the block.
  - The top level holds the FSM, index counter, carry flop and result register.

Test Plan:
1. Reset: assert rst mid-cycle (asynchronously) -> immediately out_valid=0, out_sum=0x0000, out_cout=0, busy=0, in_ready=1.
2. WIDTH=16 carry ripple across nibbles: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. out_valid rises exactly 4 edges after accept.
3. Carry-in path: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
4. Backpressure: complete a=0x8000+b=0x8000, then hold out_ready=0 for 5 cycles while driving in_valid=1 with new operands:
   - sum=0x0000 and cout=1 stay stable.
   - in_ready=0 throughout and the new operands are not accepted.
   - After out_ready pulses, the pending operands are accepted on the second following edge.
5. Reset during ADD (idx=2) -> no out_valid pulse. Then a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0.
6. WIDTH=4 exhaustive: all 512 combinations of a, b, cin issued back-to-back with out_ready=1 -> {cout,sum}==a+b+cin every time. One out_valid per accept, with zero mismatches reported.
